sseg_scan_rx: RTL and testbench

SSEG_SCAN_RX -- requirements
Module: sseg_scan_rx

---
 rtl/sseg_pkg.sv | 43 ++++
 rtl/sseg_hex_decode.sv | 20 ++
 rtl/sseg_scan_rx.sv | 121 ++++++++++++
 tb/tb_sseg_scan_rx.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared types and glyph table for the seven-segment scan receiver.
package sseg_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  // Active-low glyphs on bits 6:0 (g..a); dp is not part of the table.
  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  localparam logic [15:0][6:0] GLYPHS = {
    GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
    GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
  };

  function automatic logic onehot_low(input logic [NUM_DIGITS-1:0] a);
    return $countones(~a) == 1;
  endfunction

  function automatic logic [1:0] an_idx(input logic [NUM_DIGITS-1:0] a);
    logic [1:0] i;
    i = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (!a[k]) i = 2'(k);
    return i;
  endfunction

endpackage

// File: rtl/sseg_hex_decode.sv
// Maps a 7-bit active-low segment pattern to {hit, nibble}; unknown patterns give 0/0.
module sseg_hex_decode
  import sseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       hit,
  output logic [3:0] nib
);

  always_comb begin
    hit = 1'b0;
    nib = 4'h0;
    for (int i = 0; i < 16; i++)
      if (seg == GLYPHS[i]) begin
        hit = 1'b1;
        nib = 4'(i);
      end
  end

endmodule

// File: rtl/sseg_scan_rx.sv
// Recovers per-digit patterns from a multiplexed 4-digit seven-segment bus.
// Optional macro SSEG_RX_TIMEOUT_EN adds per-digit age counters driving stale.
module sseg_scan_rx
  import sseg_pkg::*;
#(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 262144
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [7:0]  sseg,
  output logic [31:0] digit_pat,
  output logic [15:0] hex_val,
  output logic [3:0]  valid,
  output logic [3:0]  stale,
  output logic        frame_done,
  output logic        an_err
);

  localparam logic [3:0] SETTLE_W = 4'(SETTLE_CYC);

  logic [3:0] an_r, an_d;
  logic [7:0] sseg_r, sseg_d;
  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       oh, same, cap;
  logic [1:0] idx;
  logic [NUM_DIGITS-1:0] capmask, seen, hit;
  logic [NUM_DIGITS-1:0][7:0] pat;
  logic [NUM_DIGITS-1:0][3:0] nib;

  // an_d/sseg_d hold the previous registered pair for change detection.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      an_r <= 4'hF; sseg_r <= 8'hFF; an_d <= 4'hF; sseg_d <= 8'hFF;
    end else begin
      an_r <= an; sseg_r <= sseg; an_d <= an_r; sseg_d <= sseg_r;
    end

  assign oh   = onehot_low(an_r);
  assign same = {an_r, sseg_r} == {an_d, sseg_d};
  assign idx  = an_idx(an_r);

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!oh) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE:    begin state_nxt = SETTLE; cnt_nxt = 4'd1; end
        SETTLE:  cnt_nxt = same ? cnt + 4'd1 : 4'd1;
        HELD:    if (!same) begin state_nxt = SETTLE; cnt_nxt = 4'd1; end
        default: begin state_nxt = IDLE; cnt_nxt = '0; end
      endcase
      if (state_nxt == SETTLE && cnt_nxt == SETTLE_W) state_nxt = HELD;
    end
  end

  // Capture on entry to HELD, or on a fresh pair out of HELD when SETTLE_CYC is 1.
  always_comb cap = (state_nxt == HELD) && (state != HELD || !same);

  assign capmask = cap ? ~an_r : '0;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pat        <= '1;
      seen       <= '0;
      frame_done <= 1'b0;
      an_err     <= 1'b0;
    end else begin
      if (cap) pat[idx] <= sseg_r;
      an_err     <= $countones(~an_r) > 1;
      frame_done <= &seen;
      seen       <= ((&seen) ? '0 : seen) | capmask;
    end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    sseg_hex_decode u_dec (.seg(pat[k][6:0]), .hit(hit[k]), .nib(nib[k]));
  end

  assign digit_pat = pat;
  assign hex_val   = nib;
  assign valid     = hit & ~stale;

`ifdef SSEG_RX_TIMEOUT_EN
  localparam logic [19:0] TO = 20'(TIMEOUT_CYC);
  logic [NUM_DIGITS-1:0][19:0] age;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      age   <= '0;
      stale <= '0;
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++)
        if (capmask[k]) begin
          age[k]   <= '0;
          stale[k] <= 1'b0;
        end else if (age[k] != TO) begin
          age[k] <= age[k] + 20'd1;
          if (age[k] + 20'd1 == TO) stale[k] <= 1'b1;
        end
    end
`else
  logic [19:0] unused_timeout;
  assign unused_timeout = 20'(TIMEOUT_CYC);
  assign stale = '0;
`endif

endmodule

// File: tb/tb_sseg_scan_rx.sv
// Directed bench for sseg_scan_rx (SETTLE_CYC=4, TIMEOUT_CYC=16).
module tb_sseg_scan_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  an = 4'hF;
  logic [7:0]  sseg = 8'hFF;
  logic [31:0] digit_pat;
  logic [15:0] hex_val;
  logic [3:0]  valid, stale;
  logic        frame_done, an_err;

  int errors = 0;
  int checks = 0;

  sseg_scan_rx #(.SETTLE_CYC(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .an(an), .sseg(sseg),
    .digit_pat(digit_pat), .hex_val(hex_val), .valid(valid), .stale(stale),
    .frame_done(frame_done), .an_err(an_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; an = 4'hF; sseg = 8'hFF;
    step(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    an = 4'b1110; sseg = 8'hC0;
    step(6);
    reset = 1'b1;
    #1;
    checks++; if (digit_pat !== 32'hFFFFFFFF) begin errors++; $display("FAIL rst_pat: got %h want ffffffff", digit_pat); end
    checks++; if (hex_val !== 16'h0) begin errors++; $display("FAIL rst_hex: got %h want 0000", hex_val); end
    checks++; if ({valid, stale, frame_done, an_err} !== 10'h0) begin errors++; $display("FAIL rst_flags: got %b want 0", {valid, stale, frame_done, an_err}); end
    step(1);
    reset = 1'b0; an = 4'hF; sseg = 8'hFF;
  endtask

  task automatic test_basic();
    do_reset();
    an = 4'b1110; sseg = 8'hC0;
    step(4);
    checks++; if (digit_pat[7:0] !== 8'hFF || valid[0] !== 1'b0) begin errors++; $display("FAIL basic_early: got pat %h valid %b want ff 0", digit_pat[7:0], valid[0]); end
    step(1);
    checks++; if (digit_pat[7:0] !== 8'hC0) begin errors++; $display("FAIL basic_pat: got %h want c0", digit_pat[7:0]); end
    checks++; if (hex_val[3:0] !== 4'h0 || valid[0] !== 1'b1) begin errors++; $display("FAIL basic_dec: got %h/%b want 0/1", hex_val[3:0], valid[0]); end
    step(1);
    checks++; if (digit_pat !== 32'hFFFFFFC0 || valid !== 4'b0001) begin errors++; $display("FAIL basic_hold: got %h/%b want ffffffc0/0001", digit_pat, valid); end
  endtask

  task automatic test_dp();
    do_reset();
    an = 4'b1101; sseg = 8'h79;
    step(5);
    checks++; if (digit_pat[15:8] !== 8'h79) begin errors++; $display("FAIL dp_pat: got %h want 79", digit_pat[15:8]); end
    checks++; if (hex_val[7:4] !== 4'h1 || valid[1] !== 1'b1) begin errors++; $display("FAIL dp_dec: got %h/%b want 1/1", hex_val[7:4], valid[1]); end
  endtask

  task automatic test_scan();
    logic [3:0] ans [4];
    logic [7:0] gl  [4];
    int fd_cnt, fd_at;
    logic [3:0] exp_valid;
    ans[0] = 4'b1110; ans[1] = 4'b1101; ans[2] = 4'b1011; ans[3] = 4'b0111;
    gl[0] = 8'hF9; gl[1] = 8'hA4; gl[2] = 8'hB0; gl[3] = 8'h99;
    fd_cnt = 0; fd_at = -1;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if (i < 32) begin an = ans[i/8]; sseg = gl[i/8]; end
      else begin an = 4'hF; sseg = 8'hFF; end
      step(1);
      if (frame_done === 1'b1) begin fd_cnt++; if (fd_at < 0) fd_at = i + 1; end
    end
`ifdef SSEG_RX_TIMEOUT_EN
    exp_valid = 4'b1000;
`else
    exp_valid = 4'hF;
`endif
    checks++; if (hex_val !== 16'h4321) begin errors++; $display("FAIL scan_hex: got %h want 4321", hex_val); end
    checks++; if (digit_pat !== 32'h99B0A4F9) begin errors++; $display("FAIL scan_pat: got %h want 99b0a4f9", digit_pat); end
    checks++; if (valid !== exp_valid) begin errors++; $display("FAIL scan_valid: got %b want %b", valid, exp_valid); end
    checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL scan_fd_count: got %0d want 1", fd_cnt); end
    checks++; if (fd_at !== 30) begin errors++; $display("FAIL scan_fd_cycle: got %0d want 30", fd_at); end
  endtask

  task automatic test_toggle();
    do_reset();
    an = 4'b1110;
    for (int i = 0; i < 16; i++) begin
      sseg = ((i / 2) % 2 == 0) ? 8'hC0 : 8'hF9;
      step(1);
    end
    checks++; if (digit_pat !== 32'hFFFFFFFF || valid !== 4'h0 || hex_val !== 16'h0) begin errors++; $display("FAIL toggle_nocap: got %h/%b/%h want ffffffff/0000/0000", digit_pat, valid, hex_val); end
  endtask

  task automatic test_an_err();
    int n;
    n = 0;
    do_reset();
    an = 4'b1100; sseg = 8'hC0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) an = 4'hF;
      step(1);
      if (an_err === 1'b1) n++;
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL an_err_count: got %0d want 3", n); end
    checks++; if (digit_pat !== 32'hFFFFFFFF || valid !== 4'h0) begin errors++; $display("FAIL an_err_nocap: got %h/%b want ffffffff/0000", digit_pat, valid); end
  endtask

  task automatic test_blank();
    do_reset();
    an = 4'b1011; sseg = 8'hC0;
    step(6);
    checks++; if (digit_pat[23:16] !== 8'hC0 || valid[2] !== 1'b1) begin errors++; $display("FAIL blank_pre: got %h/%b want c0/1", digit_pat[23:16], valid[2]); end
    sseg = 8'hFF;
    step(6);
    checks++; if (digit_pat[23:16] !== 8'hFF) begin errors++; $display("FAIL blank_pat: got %h want ff", digit_pat[23:16]); end
    checks++; if (valid[2] !== 1'b0 || hex_val[11:8] !== 4'h0) begin errors++; $display("FAIL blank_dec: got %b/%h want 0/0", valid[2], hex_val[11:8]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    an = 4'b1110; sseg = 8'hF9;
    step(3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);
    checks++; if (digit_pat !== 32'hFFFFFFFF || valid !== 4'h0) begin errors++; $display("FAIL rstmid_first: got %h/%b want ffffffff/0000", digit_pat, valid); end
    step(3);
    checks++; if (digit_pat[7:0] !== 8'hFF) begin errors++; $display("FAIL rstmid_early: got %h want ff", digit_pat[7:0]); end
    step(1);
    checks++; if (digit_pat[7:0] !== 8'hF9 || hex_val[3:0] !== 4'h1) begin errors++; $display("FAIL rstmid_cap: got %h/%h want f9/1", digit_pat[7:0], hex_val[3:0]); end
  endtask

  task automatic test_timeout();
    do_reset();
    an = 4'b1110; sseg = 8'hC0;
    step(5);
    an = 4'hF; sseg = 8'hFF;
`ifdef SSEG_RX_TIMEOUT_EN
    step(15);
    checks++; if (stale[0] !== 1'b0 || valid[0] !== 1'b1) begin errors++; $display("FAIL to_before: got %b/%b want 0/1", stale[0], valid[0]); end
    step(1);
    checks++; if (stale[0] !== 1'b1 || valid[0] !== 1'b0) begin errors++; $display("FAIL to_stale: got %b/%b want 1/0", stale[0], valid[0]); end
    an = 4'b1110; sseg = 8'hC0;
    step(5);
    checks++; if (stale[0] !== 1'b0 || valid[0] !== 1'b1) begin errors++; $display("FAIL to_recap: got %b/%b want 0/1", stale[0], valid[0]); end
`else
    step(40);
    checks++; if (stale !== 4'h0 || valid[0] !== 1'b1) begin errors++; $display("FAIL to_disabled: got %b/%b want 0000/1", stale, valid[0]); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dp();
    test_scan();
    test_toggle();
    test_an_err();
    test_blank();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
